load_store_pipe: RTL and testbench

LOAD_STORE_PIPE -- requirements
Module: load_store_pipe

---
 rtl/load_store_pipe.sv | 278 +++++++++++++++++++++++++++
 tb/tb_load_store_pipe.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_pipe.sv
// rtl/load_store_pipe.sv - in-order load/store issue pipe with port decode, in-order load return and writeback FIFO
// Optional feature macro LS_LOAD_FORWARD_EN: last acked load replaces store data when in_fwd=1.
module load_store_pipe #(
  parameter int XLEN         = 32,
  parameter int NUM_PORTS    = 3,
  parameter int IN_DEPTH     = 4,
  parameter int MAX_INFLIGHT = 4,
  parameter int OUT_DEPTH    = 2,
  parameter logic [NUM_PORTS-1:0][XLEN-1:0] PORT_BASE =
    {XLEN'(32'h2000_0000), XLEN'(32'h1000_0000), XLEN'(32'h8000_0000)},
  parameter logic [NUM_PORTS-1:0][XLEN-1:0] PORT_MASK =
    {XLEN'(32'hF000_0000), XLEN'(32'hF000_0000), XLEN'(32'hF000_0000)}
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_load,
  input  logic                      in_store,
  input  logic                      in_fwd,
  input  logic [2:0]                in_fn3,
  input  logic [XLEN-1:0]           in_addr,
  input  logic [XLEN-1:0]           in_wdata,
  output logic [NUM_PORTS-1:0]      p_req_valid,
  input  logic [NUM_PORTS-1:0]      p_req_ready,
  output logic [XLEN-1:0]           p_addr,
  output logic [XLEN-1:0]           p_wdata,
  output logic [XLEN/8-1:0]         p_be,
  output logic                      p_rnw,
  input  logic [NUM_PORTS-1:0]      p_resp_valid,
  input  logic [NUM_PORTS*XLEN-1:0] p_resp_data,
  output logic [NUM_PORTS-1:0]      p_resp_ack,
  output logic                      wb_valid,
  output logic [XLEN-1:0]           wb_data,
  input  logic                      wb_accept,
  output logic                      exc_valid,
  output logic                      exc_misaligned,
  output logic [XLEN-1:0]           exc_addr
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int PW   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int IAW  = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
  localparam int AAW  = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int OAW  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int ICW  = $clog2(IN_DEPTH + 1);
  localparam int ACW  = $clog2(MAX_INFLIGHT + 1);
  localparam int OCW  = $clog2(OUT_DEPTH + 1);

  logic [XLEN-1:0] iq_addr_q  [IN_DEPTH];
  logic [XLEN-1:0] iq_wdata_q [IN_DEPTH];
  logic [2:0]      iq_fn3_q   [IN_DEPTH];
  logic            iq_load_q  [IN_DEPTH];
  logic [IAW-1:0]  iq_wr_q, iq_wr_d, iq_rd_q, iq_rd_d;
  logic [ICW-1:0]  iq_cnt_q, iq_cnt_d;

  logic [PW-1:0]   aq_port_q [MAX_INFLIGHT];
  logic [2:0]      aq_fn3_q  [MAX_INFLIGHT];
  logic [OFFW-1:0] aq_off_q  [MAX_INFLIGHT];
  logic [AAW-1:0]  aq_wr_q, aq_wr_d, aq_rd_q, aq_rd_d;
  logic [ACW-1:0]  aq_cnt_q, aq_cnt_d;

  logic [XLEN-1:0] oq_q [OUT_DEPTH];
  logic [OAW-1:0]  oq_wr_q, oq_wr_d, oq_rd_q, oq_rd_d;
  logic [OCW-1:0]  oq_cnt_q, oq_cnt_d;

  logic [ACW-1:0]  inflight_q, inflight_d;

  logic            iq_full, iq_push, iq_pop;
  logic            h_valid, h_load, h_fwd, hit, mis, fault, sel_ready, fwd_wait;
  logic [2:0]      h_fn3;
  logic [XLEN-1:0] h_addr, h_wdata, st_src, st_wd;
  logic [OFFW-1:0] h_off;
  logic [PW-1:0]   h_port;
  logic [NB-1:0]   st_be;
  logic            issue, ld_issue;
  logic            a_valid, wb_full, ack_any, wb_pop;
  logic [XLEN-1:0] rdata, sh, ld_val;

  // Head of the request FIFO
  assign iq_full = (iq_cnt_q == ICW'(IN_DEPTH));
  assign in_ready = rst & ~iq_full;
  assign iq_push  = in_valid & in_ready & (in_load | in_store);
  assign h_valid  = (iq_cnt_q != '0);
  assign h_addr   = iq_addr_q[iq_rd_q];
  assign h_wdata  = iq_wdata_q[iq_rd_q];
  assign h_fn3    = iq_fn3_q[iq_rd_q];
  assign h_load   = iq_load_q[iq_rd_q];
  assign h_off    = h_addr[OFFW-1:0];

`ifdef LS_LOAD_FORWARD_EN
  logic            iq_fwd_q [IN_DEPTH];
  logic [XLEN-1:0] ll_q;

  always_ff @(posedge clk) begin
    if (iq_push) iq_fwd_q[iq_wr_q] <= in_fwd;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         ll_q <= '0;
    else if (ack_any) ll_q <= ld_val;
  end

  assign h_fwd    = iq_fwd_q[iq_rd_q] & ~h_load;
  assign fwd_wait = h_fwd & (inflight_q != '0);
  assign st_src   = h_fwd ? ll_q : h_wdata;
`else
  logic unused_fwd;
  assign unused_fwd = in_fwd;
  assign h_fwd      = 1'b0;
  assign fwd_wait   = 1'b0;
  assign st_src     = h_wdata;
`endif

  // Lowest-numbered matching port wins; scan from the top so lower indices overwrite
  always_comb begin
    hit       = 1'b0;
    h_port    = '0;
    sel_ready = 1'b0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if ((h_addr & PORT_MASK[i]) == PORT_BASE[i]) begin
        hit    = 1'b1;
        h_port = PW'(i);
      end
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (h_port == PW'(i)) sel_ready = p_req_ready[i];
    end
  end

  always_comb begin
    mis = 1'b0;
    case (h_fn3[1:0])
      2'b01:   mis = h_addr[0];
      2'b10:   mis = (h_addr[1:0] != 2'b00);
      2'b11:   mis = (XLEN == 64) ? (h_addr[2:0] != 3'b000) : (h_addr[1:0] != 2'b00);
      default: mis = 1'b0;
    endcase
  end

  assign fault    = mis | ~hit;
  assign issue    = h_valid & ~fault & sel_ready &
                    (h_load ? (inflight_q < ACW'(MAX_INFLIGHT)) : ~fwd_wait);
  assign ld_issue = issue & h_load;
  assign exc_valid      = h_valid & fault & (inflight_q == '0);
  assign exc_misaligned = mis;
  assign exc_addr       = h_addr;
  assign iq_pop   = issue | exc_valid;

  always_comb begin
    st_be = '1;
    st_wd = st_src;
    case (h_fn3[1:0])
      2'b00: begin
        st_be = NB'(1) << h_off;
        st_wd = {NB{st_src[7:0]}};
      end
      2'b01: begin
        st_be = NB'(3) << h_off;
        st_wd = {(NB/2){st_src[15:0]}};
      end
      2'b10: begin
        st_be = NB'(15) << h_off;
        st_wd = {(NB/4){st_src[31:0]}};
      end
      default: begin
        st_be = '1;
        st_wd = st_src;
      end
    endcase
  end

  always_comb begin
    p_req_valid = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      p_req_valid[i] = issue & (h_port == PW'(i));
    end
  end

  assign p_addr  = h_addr;
  assign p_rnw   = h_load;
  assign p_be    = h_load ? '0 : st_be;
  assign p_wdata = st_wd;

  // Responses are only taken from the port the oldest outstanding load went to
  assign a_valid = (aq_cnt_q != '0);
  assign wb_full = (oq_cnt_q == OCW'(OUT_DEPTH));

  always_comb begin
    p_resp_ack = '0;
    rdata      = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      p_resp_ack[i] = a_valid & ~wb_full & p_resp_valid[i] & (aq_port_q[aq_rd_q] == PW'(i));
      if (aq_port_q[aq_rd_q] == PW'(i)) rdata = p_resp_data[i*XLEN +: XLEN];
    end
  end

  assign ack_any = |p_resp_ack;
  assign sh      = rdata >> {aq_off_q[aq_rd_q], 3'b000};

  always_comb begin
    ld_val = sh;
    case (aq_fn3_q[aq_rd_q])
      3'b000:  ld_val = XLEN'($signed(sh[7:0]));
      3'b001:  ld_val = XLEN'($signed(sh[15:0]));
      3'b010:  ld_val = XLEN'($signed(sh[31:0]));
      3'b100:  ld_val = XLEN'(sh[7:0]);
      3'b101:  ld_val = XLEN'(sh[15:0]);
      3'b110:  ld_val = XLEN'(sh[31:0]);
      default: ld_val = sh;
    endcase
  end

  assign wb_valid = (oq_cnt_q != '0);
  assign wb_data  = oq_q[oq_rd_q];
  assign wb_pop   = wb_valid & wb_accept;

  always_comb begin
    iq_wr_d  = iq_push ? ((iq_wr_q == IAW'(IN_DEPTH - 1)) ? '0 : iq_wr_q + IAW'(1)) : iq_wr_q;
    iq_rd_d  = iq_pop ? ((iq_rd_q == IAW'(IN_DEPTH - 1)) ? '0 : iq_rd_q + IAW'(1)) : iq_rd_q;
    iq_cnt_d = iq_cnt_q + ICW'(iq_push) - ICW'(iq_pop);
    aq_wr_d  = ld_issue ? ((aq_wr_q == AAW'(MAX_INFLIGHT - 1)) ? '0 : aq_wr_q + AAW'(1)) : aq_wr_q;
    aq_rd_d  = ack_any ? ((aq_rd_q == AAW'(MAX_INFLIGHT - 1)) ? '0 : aq_rd_q + AAW'(1)) : aq_rd_q;
    aq_cnt_d = aq_cnt_q + ACW'(ld_issue) - ACW'(ack_any);
    oq_wr_d  = ack_any ? ((oq_wr_q == OAW'(OUT_DEPTH - 1)) ? '0 : oq_wr_q + OAW'(1)) : oq_wr_q;
    oq_rd_d  = wb_pop ? ((oq_rd_q == OAW'(OUT_DEPTH - 1)) ? '0 : oq_rd_q + OAW'(1)) : oq_rd_q;
    oq_cnt_d = oq_cnt_q + OCW'(ack_any) - OCW'(wb_pop);
    case ({ld_issue, wb_pop})
      2'b10:   inflight_d = inflight_q + ACW'(1);
      2'b01:   inflight_d = inflight_q - ACW'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iq_wr_q    <= '0;
      iq_rd_q    <= '0;
      iq_cnt_q   <= '0;
      aq_wr_q    <= '0;
      aq_rd_q    <= '0;
      aq_cnt_q   <= '0;
      oq_wr_q    <= '0;
      oq_rd_q    <= '0;
      oq_cnt_q   <= '0;
      inflight_q <= '0;
    end else begin
      iq_wr_q    <= iq_wr_d;
      iq_rd_q    <= iq_rd_d;
      iq_cnt_q   <= iq_cnt_d;
      aq_wr_q    <= aq_wr_d;
      aq_rd_q    <= aq_rd_d;
      aq_cnt_q   <= aq_cnt_d;
      oq_wr_q    <= oq_wr_d;
      oq_rd_q    <= oq_rd_d;
      oq_cnt_q   <= oq_cnt_d;
      inflight_q <= inflight_d;
    end
  end

  // Payload storage needs no reset: occupancy counters gate every read
  always_ff @(posedge clk) begin
    if (iq_push) begin
      iq_addr_q[iq_wr_q]  <= in_addr;
      iq_wdata_q[iq_wr_q] <= in_wdata;
      iq_fn3_q[iq_wr_q]   <= in_fn3;
      iq_load_q[iq_wr_q]  <= in_load;
    end
    if (ld_issue) begin
      aq_port_q[aq_wr_q] <= h_port;
      aq_fn3_q[aq_wr_q]  <= h_fn3;
      aq_off_q[aq_wr_q]  <= h_off;
    end
    if (ack_any) oq_q[oq_wr_q] <= ld_val;
  end

endmodule

// File: tb/tb_load_store_pipe.sv
// tb/tb_load_store_pipe.sv - directed self-checking bench for load_store_pipe with latency-programmable port models
module tb_load_store_pipe;
  localparam int NP = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_load, in_store, in_fwd;
  logic [2:0]    in_fn3;
  logic [31:0]   in_addr, in_wdata;
  logic [NP-1:0] p_req_valid, p_req_ready;
  logic [31:0]   p_addr, p_wdata;
  logic [3:0]    p_be;
  logic          p_rnw;
  logic [NP-1:0] p_resp_valid, p_resp_ack;
  logic [NP*32-1:0] p_resp_data;
  logic          wb_valid, wb_accept;
  logic [31:0]   wb_data;
  logic          exc_valid, exc_misaligned;
  logic [31:0]   exc_addr;

  always #5 clk = ~clk;

  load_store_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_load(in_load), .in_store(in_store),
    .in_fwd(in_fwd), .in_fn3(in_fn3), .in_addr(in_addr), .in_wdata(in_wdata),
    .p_req_valid(p_req_valid), .p_req_ready(p_req_ready), .p_addr(p_addr),
    .p_wdata(p_wdata), .p_be(p_be), .p_rnw(p_rnw),
    .p_resp_valid(p_resp_valid), .p_resp_data(p_resp_data), .p_resp_ack(p_resp_ack),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_accept(wb_accept),
    .exc_valid(exc_valid), .exc_misaligned(exc_misaligned), .exc_addr(exc_addr)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] port_data [NP];
  int          lat [NP];
  int          rsp_due [NP][$];
  logic [31:0] rsp_dat [NP][$];

  int          req_cyc[$], req_port[$];
  logic [31:0] req_addr[$], req_wd[$];
  logic [3:0]  req_be[$];
  logic        req_rnw[$];
  logic [31:0] wb_dat[$];
  int          wb_cyc[$];
  int          exc_cyc[$];
  logic [31:0] exc_ad[$];
  logic        exc_mis[$];
  int          held0, ack_cnt;
  logic [NP-1:0] fire_rd, ackd;

  // Port models and monitors: observe at negedge, update responses just after posedge
  initial begin
    p_resp_valid = '0;
    p_resp_data  = '0;
    forever begin
      @(negedge clk);
      fire_rd = '0;
      ackd    = p_resp_ack;
      for (int i = 0; i < NP; i++) begin
        if (p_req_valid[i] && p_req_ready[i]) begin
          req_cyc.push_back(cyc);
          req_port.push_back(i);
          req_addr.push_back(p_addr);
          req_wd.push_back(p_wdata);
          req_be.push_back(p_be);
          req_rnw.push_back(p_rnw);
          if (p_rnw) fire_rd[i] = 1'b1;
        end
      end
      if (wb_valid && wb_accept) begin
        wb_dat.push_back(wb_data);
        wb_cyc.push_back(cyc);
      end
      if (exc_valid) begin
        exc_cyc.push_back(cyc);
        exc_ad.push_back(exc_addr);
        exc_mis.push_back(exc_misaligned);
      end
      if (p_resp_valid[0] && !p_resp_ack[0]) held0++;
      if (|p_resp_ack) ack_cnt++;
      @(posedge clk);
      #1;
      for (int i = 0; i < NP; i++) begin
        if (ackd[i] && rsp_due[i].size() > 0) begin
          void'(rsp_due[i].pop_front());
          void'(rsp_dat[i].pop_front());
        end
        if (fire_rd[i]) begin
          rsp_due[i].push_back(cyc + lat[i] - 1);
          rsp_dat[i].push_back(port_data[i]);
        end
        p_resp_valid[i] = (rsp_due[i].size() > 0) && (rsp_due[i][0] <= cyc);
        p_resp_data[i*32 +: 32] = (rsp_dat[i].size() > 0) ? rsp_dat[i][0] : 32'h0;
      end
    end
  end

  task automatic clear_mon();
    req_cyc.delete(); req_port.delete(); req_addr.delete();
    req_wd.delete(); req_be.delete(); req_rnw.delete();
    wb_dat.delete(); wb_cyc.delete();
    exc_cyc.delete(); exc_ad.delete(); exc_mis.delete();
    held0 = 0;
    ack_cnt = 0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic ld, input logic fwd, input logic [2:0] fn3,
                      input logic [31:0] addr, input logic [31:0] wd, output int acc);
    in_valid = 1'b1; in_load = ld; in_store = ~ld; in_fwd = fwd;
    in_fn3 = fn3; in_addr = addr; in_wdata = wd;
    acc = -1;
    for (int n = 0; n < 50 && acc < 0; n++) begin
      @(negedge clk);
      if (in_ready) acc = cyc;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0; in_fwd = 1'b0;
    if (acc < 0) check("send_timeout", 0, 1);
  endtask

  task automatic wait_wb(input int n);
    for (int k = 0; k < 200 && wb_dat.size() < n; k++) wait_cycles(1);
    check("wb_count", wb_dat.size(), n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int a, b, c;

  initial begin
    rst = 1'b0;
    in_valid = 0; in_load = 0; in_store = 0; in_fwd = 0;
    in_fn3 = 0; in_addr = 0; in_wdata = 0;
    p_req_ready = '1;
    wb_accept = 1'b1;
    for (int i = 0; i < NP; i++) begin
      lat[i] = 1;
      port_data[i] = 32'h0;
    end
    clear_mon();

    #3;
    check("rst_in_ready", in_ready, 0);
    check("rst_req_valid", p_req_valid, 0);
    check("rst_resp_ack", p_resp_ack, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_exc_valid", exc_valid, 0);
    #19 rst = 1'b1;
    wait_cycles(2);

    // LB from byte 3 of 0x80FF_0000 sign-extends 0x80
    port_data[0] = 32'h80FF_0000;
    clear_mon();
    send(1, 0, 3'b000, 32'h8000_0003, 32'h0, a);
    wait_wb(1);
    check("lb_req_cycle", req_cyc[0], a + 1);
    check("lb_req_port", req_port[0], 0);
    check("lb_req_rnw", req_rnw[0], 1);
    check("lb_req_be", req_be[0], 0);
    check("lb_req_addr", req_addr[0], 32'h8000_0003);
    check("lb_wb_data", wb_dat[0], 32'hFFFF_FF80);
    check("lb_wb_cycle", wb_cyc[0], a + 3);

    // Slow port 2 then fast port 0: port 0 held until port 2 returns
    lat[2] = 5;
    port_data[2] = 32'h2222_2222;
    wait_cycles(2);
    clear_mon();
    send(1, 0, 3'b010, 32'h2000_0000, 32'h0, a);
    send(1, 0, 3'b010, 32'h8000_0004, 32'h0, b);
    wait_wb(2);
    check("order_first", wb_dat[0], 32'h2222_2222);
    check("order_second", wb_dat[1], 32'h80FF_0000);
    check("order_held_cycles", held0, 4);

    // Misaligned LW behind two loads waits for both to retire
    wait_cycles(2);
    clear_mon();
    send(1, 0, 3'b010, 32'h2000_0000, 32'h0, a);
    send(1, 0, 3'b010, 32'h8000_0000, 32'h0, b);
    send(1, 0, 3'b010, 32'h8000_0002, 32'h0, c);
    wait_wb(2);
    wait_cycles(4);
    check("mis_exc_count", exc_cyc.size(), 1);
    check("mis_exc_cycle", exc_cyc[0], wb_cyc[1] + 1);
    check("mis_exc_flag", exc_mis[0], 1);
    check("mis_exc_addr", exc_ad[0], 32'h8000_0002);
    check("mis_no_issue", req_cyc.size(), 2);

    // Unmapped address faults immediately with misaligned clear
    clear_mon();
    send(1, 0, 3'b010, 32'h4000_0000, 32'h0, a);
    wait_cycles(3);
    check("af_exc_cycle", exc_cyc[0], a + 1);
    check("af_exc_mis", exc_mis[0], 0);
    check("af_exc_addr", exc_ad[0], 32'h4000_0000);
    check("af_no_issue", req_cyc.size(), 0);

    // Stores: byte enables and lane replication
    clear_mon();
    send(0, 0, 3'b010, 32'h1000_0004, 32'hAABB_CCDD, a);
    send(0, 0, 3'b000, 32'h1000_0002, 32'h0000_00EE, a);
    send(0, 0, 3'b001, 32'h1000_0002, 32'h1234_BEEF, a);
    send(0, 0, 3'b001, 32'h1000_0001, 32'h1234_BEEF, a);
    wait_cycles(3);
    check("st_req_count", req_cyc.size(), 3);
    check("sw_port", req_port[0], 1);
    check("sw_rnw", req_rnw[0], 0);
    check("sw_be", req_be[0], 4'hF);
    check("sw_wdata", req_wd[0], 32'hAABB_CCDD);
    check("sb_be", req_be[1], 4'h4);
    check("sb_wdata", req_wd[1], 32'hEEEE_EEEE);
    check("sh_be", req_be[2], 4'hC);
    check("sh_wdata", req_wd[2], 32'hBEEF_BEEF);
    check("sh_mis_exc", exc_mis[0], 1);
    check("sh_mis_addr", exc_ad[0], 32'h1000_0001);
    check("st_no_wb", wb_dat.size(), 0);

    // Inflight cap: fifth load waits for one writeback pop
    port_data[0] = 32'h0000_0C35;
    wb_accept = 1'b0;
    clear_mon();
    for (int k = 0; k < 5; k++) send(1, 0, 3'b010, 32'h8000_0000, 32'h0, a);
    wait_cycles(8);
    check("cap_reqs_before", req_cyc.size(), 4);
    check("cap_wb_pending", wb_valid, 1);
    wb_accept = 1'b1;
    c = cyc;
    wait_cycles(1);
    wb_accept = 1'b0;
    wait_cycles(2);
    check("cap_reqs_after", req_cyc.size(), 5);
    check("cap_fifth_cycle", req_cyc[4], c + 1);
    wb_accept = 1'b1;
    wait_wb(5);
    check("cap_last_data", wb_dat[4], 32'h0000_0C35);

`ifdef LS_LOAD_FORWARD_EN
    // Forwarded store data comes from the last load, replicated per byte
    port_data[0] = 32'h1234_5678;
    wait_cycles(2);
    clear_mon();
    send(1, 0, 3'b010, 32'h8000_0000, 32'h0, a);
    wait_wb(1);
    send(0, 1, 3'b000, 32'h1000_0001, 32'h0000_0000, b);
    wait_cycles(3);
    check("fwd_wdata", req_wd[1], 32'h7878_7878);
    check("fwd_be", req_be[1], 4'b0010);
`endif

    // Reset with two loads outstanding on the slow port
    wait_cycles(2);
    clear_mon();
    send(1, 0, 3'b010, 32'h2000_0000, 32'h0, a);
    send(1, 0, 3'b010, 32'h2000_0000, 32'h0, b);
    wait_cycles(1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_req_valid", p_req_valid, 0);
    check("mid_rst_resp_ack", p_resp_ack, 0);
    check("mid_rst_wb_valid", wb_valid, 0);
    check("mid_rst_exc_valid", exc_valid, 0);
    wait_cycles(2);
    #2 rst = 1'b1;
    ack_cnt = 0;
    wb_dat.delete();
    wait_cycles(12);
    check("stale_acks", ack_cnt, 0);
    check("stale_wb", wb_dat.size(), 0);
    check("post_rst_in_ready", in_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
